// File: rtl/crossbar_nm_rr_pkg.sv
// Shared definitions for the N-master x M-slave round-robin crossbar.
// Holds the per-slave FSM encoding, command constants and a ceil-log2 helper.
package crossbar_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    localparam logic CMD_READ  = 1'b0;
    localparam logic CMD_WRITE = 1'b1;

    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) width++;
        return width;
    endfunction

endpackage

// File: rtl/crossbar_nm_rr_arbiter.sv
// Round-robin arbiter: the search starts at the pointer and wraps around.
// On advance, the pointer moves to one past the granted requester.
module rr_arbiter
    import crossbar_pkg::*;
#(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant_onehot,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] upper_idx;
    logic [IW-1:0] lower_idx;
    logic          upper_found;
    logic          any_req;

    // Prefer the lowest requester at or above the pointer, else the lowest overall.
    always_comb begin
        upper_idx   = '0;
        lower_idx   = '0;
        upper_found = 1'b0;
        any_req     = 1'b0;
        for (int j = N - 1; j >= 0; j--) begin
            if (req[j]) begin
                lower_idx = IW'(j);
                any_req   = 1'b1;
                if (j >= int'(ptr)) begin
                    upper_idx   = IW'(j);
                    upper_found = 1'b1;
                end
            end
        end
        grant_idx = upper_found ? upper_idx : lower_idx;
        for (int j = 0; j < N; j++) begin
            grant_onehot[j] = any_req && (grant_idx == IW'(j));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (int'(grant_idx) == N - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/crossbar_nm_rr.sv
// Registered NUM_M x NUM_S request/acknowledge crossbar with one round-robin arbiter per slave.
// Define CROSSBAR_TIMEOUT_EN to add a per-slave watchdog that answers stuck transfers with master_err.
module crossbar_nm_rr
    import crossbar_pkg::*;
#(
    parameter int NUM_M          = 2,
    parameter int NUM_S          = 2,
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_M-1:0]          master_req,
    input  logic [NUM_M*ADDR_W-1:0]   master_addr,
    input  logic [NUM_M-1:0]          master_cmd,
    input  logic [NUM_M*DATA_W-1:0]   master_wdata,
    output logic [NUM_M-1:0]          master_ack,
    output logic [NUM_M*DATA_W-1:0]   master_rdata,
    output logic [NUM_M-1:0]          master_err,
    output logic [NUM_S-1:0]          slave_req,
    output logic [NUM_S*ADDR_W-1:0]   slave_addr,
    output logic [NUM_S-1:0]          slave_cmd,
    output logic [NUM_S*DATA_W-1:0]   slave_wdata,
    input  logic [NUM_S-1:0]          slave_ack,
    input  logic [NUM_S*DATA_W-1:0]   slave_rdata
);

    localparam int SW = clog2(NUM_S);
    localparam int MW = (NUM_M > 1) ? clog2(NUM_M) : 1;

    logic [NUM_M-1:0]  slave_hit [NUM_S];
    logic [NUM_S-1:0]  done_v;
    logic [NUM_S-1:0]  err_v;
    logic [MW-1:0]     owner_v [NUM_S];
    logic [DATA_W-1:0] rdata_v [NUM_S];

    // The top address bits pick the slave; the full address is still forwarded.
    always_comb begin
        for (int s = 0; s < NUM_S; s++) begin
            for (int m = 0; m < NUM_M; m++) begin
                slave_hit[s][m] = master_req[m] &&
                    (master_addr[m*ADDR_W + ADDR_W - 1 -: SW] == SW'(s));
            end
        end
    end

    for (genvar s = 0; s < NUM_S; s++) begin : g_slave
        state_t            state;
        state_t            next_state;
        logic [NUM_M-1:0]  grant_onehot;
        logic [MW-1:0]     grant_idx;
        logic [MW-1:0]     owner;
        logic              own_req;
        logic              own_cmd;
        logic [ADDR_W-1:0] own_addr;
        logic [DATA_W-1:0] own_wdata;
        logic              ack_fire;
        logic              timeout_fire;
        logic              fwd_req;
        logic              fwd_cmd;
        logic [ADDR_W-1:0] fwd_addr;
        logic [DATA_W-1:0] fwd_wdata;
        logic [DATA_W-1:0] fwd_rdata;
        logic              done;
        logic              err;

        rr_arbiter #(
            .N  (NUM_M),
            .IW (MW)
        ) u_arbiter (
            .clk          (clk),
            .rst_n        (rst_n),
            .req          (slave_hit[s]),
            .advance      ((state == ST_IDLE) && (|grant_onehot)),
            .grant_onehot (grant_onehot),
            .grant_idx    (grant_idx)
        );

        always_comb begin
            own_req   = 1'b0;
            own_cmd   = CMD_READ;
            own_addr  = '0;
            own_wdata = '0;
            for (int m = 0; m < NUM_M; m++) begin
                if (owner == MW'(m)) begin
                    own_req   = master_req[m];
                    own_cmd   = master_cmd[m];
                    own_addr  = master_addr[m*ADDR_W +: ADDR_W];
                    own_wdata = master_wdata[m*DATA_W +: DATA_W];
                end
            end
        end

        assign ack_fire = (state == ST_BUSY) && own_req && slave_ack[s];

`ifdef CROSSBAR_TIMEOUT_EN
        localparam int CW = clog2(TIMEOUT_CYCLES + 1);
        logic [CW-1:0] wd_count;

        // Counts unacknowledged BUSY cycles; the TIMEOUT_CYCLES-th one answers with an error.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                wd_count <= '0;
            end else if (state != ST_BUSY) begin
                wd_count <= '0;
            end else if (!slave_ack[s]) begin
                wd_count <= wd_count + 1'b1;
            end
        end

        assign timeout_fire = (state == ST_BUSY) && own_req && !slave_ack[s] &&
                              (wd_count == CW'(TIMEOUT_CYCLES - 1));
`else
        assign timeout_fire = 1'b0;
`endif

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state <= ST_IDLE;
                owner <= '0;
            end else begin
                state <= next_state;
                if ((state == ST_IDLE) && (|grant_onehot)) begin
                    owner <= grant_idx;
                end
            end
        end

        // An owner that drops req mid-transfer simply abandons the slot.
        always_comb begin
            next_state = state;
            case (state)
                ST_IDLE: if (|grant_onehot) next_state = ST_BUSY;
                ST_BUSY: if (!own_req || slave_ack[s] || timeout_fire) next_state = ST_IDLE;
                default: next_state = ST_IDLE;
            endcase
        end

        always_comb begin
            fwd_req   = 1'b0;
            fwd_cmd   = 1'b0;
            fwd_addr  = '0;
            fwd_wdata = '0;
            fwd_rdata = '0;
            done      = 1'b0;
            err       = 1'b0;
            if (state == ST_BUSY) begin
                fwd_req   = 1'b1;
                fwd_cmd   = own_cmd;
                fwd_addr  = own_addr;
                fwd_wdata = own_wdata;
                if (ack_fire) begin
                    done      = 1'b1;
                    fwd_rdata = (own_cmd == CMD_WRITE) ? '0 : slave_rdata[s*DATA_W +: DATA_W];
                end else if (timeout_fire) begin
                    done = 1'b1;
                    err  = 1'b1;
                end
            end
        end

        assign slave_req[s]                      = fwd_req;
        assign slave_cmd[s]                      = fwd_cmd;
        assign slave_addr[s*ADDR_W +: ADDR_W]    = fwd_addr;
        assign slave_wdata[s*DATA_W +: DATA_W]   = fwd_wdata;
        assign done_v[s]                         = done;
        assign err_v[s]                          = err;
        assign owner_v[s]                        = owner;
        assign rdata_v[s]                        = fwd_rdata;
    end

    // A master owns at most one slave, so OR-ing the per-slave responses never collides.
    always_comb begin
        master_ack   = '0;
        master_err   = '0;
        master_rdata = '0;
        for (int s = 0; s < NUM_S; s++) begin
            for (int m = 0; m < NUM_M; m++) begin
                if (done_v[s] && (owner_v[s] == MW'(m))) begin
                    master_ack[m]                   = 1'b1;
                    master_err[m]                   = err_v[s];
                    master_rdata[m*DATA_W +: DATA_W] = rdata_v[s];
                end
            end
        end
    end

endmodule

// File: tb/tb_crossbar_nm_rr.sv
// Self-checking bench for crossbar_nm_rr: directed scenarios plus a randomized run against a transaction model.
// The watchdog scenario is compiled only when CROSSBAR_TIMEOUT_EN is defined.
module tb_crossbar_nm_rr;
    import crossbar_pkg::*;

    localparam int NUM_M   = 2;
    localparam int NUM_S   = 2;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 8;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [NUM_M-1:0]        master_req;
    logic [NUM_M*ADDR_W-1:0] master_addr;
    logic [NUM_M-1:0]        master_cmd;
    logic [NUM_M*DATA_W-1:0] master_wdata;
    logic [NUM_M-1:0]        master_ack;
    logic [NUM_M*DATA_W-1:0] master_rdata;
    logic [NUM_M-1:0]        master_err;
    logic [NUM_S-1:0]        slave_req;
    logic [NUM_S*ADDR_W-1:0] slave_addr;
    logic [NUM_S-1:0]        slave_cmd;
    logic [NUM_S*DATA_W-1:0] slave_wdata;
    logic [NUM_S-1:0]        slave_ack;
    logic [NUM_S*DATA_W-1:0] slave_rdata;

    int tests_run    = 0;
    int tests_failed = 0;
    int cyc          = 0;

    crossbar_nm_rr #(
        .NUM_M          (NUM_M),
        .NUM_S          (NUM_S),
        .ADDR_W         (ADDR_W),
        .DATA_W         (DATA_W),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .master_req   (master_req),
        .master_addr  (master_addr),
        .master_cmd   (master_cmd),
        .master_wdata (master_wdata),
        .master_ack   (master_ack),
        .master_rdata (master_rdata),
        .master_err   (master_err),
        .slave_req    (slave_req),
        .slave_addr   (slave_addr),
        .slave_cmd    (slave_cmd),
        .slave_wdata  (slave_wdata),
        .slave_ack    (slave_ack),
        .slave_rdata  (slave_rdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("[TB] FAIL global_watchdog: simulation did not finish in time");
        $fatal(1, "[TB] global watchdog expired");
    end

    task automatic idle_inputs();
        master_req   = '0;
        master_addr  = '0;
        master_cmd   = '0;
        master_wdata = '0;
        slave_ack    = '0;
        slave_rdata  = '0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        idle_inputs();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic set_master(input int m, input logic req, input logic [ADDR_W-1:0] addr,
                              input logic cmd, input logic [DATA_W-1:0] wdata);
        master_req[m]                    = req;
        master_addr[m*ADDR_W +: ADDR_W]  = addr;
        master_cmd[m]                    = cmd;
        master_wdata[m*DATA_W +: DATA_W] = wdata;
    endtask

    // Called at posedge+1; returns at the negedge where slave_req[s] is seen high, or gives up.
    task automatic wait_slave_req(input int s, output bit ok);
        int n;
        n = 0;
        @(negedge clk);
        while (slave_req[s] !== 1'b1 && n < 10) begin
            next_cycle();
            @(negedge clk);
            n++;
        end
        ok = (slave_req[s] === 1'b1);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        master_req  = '1;
        master_addr = {32'h8000_0010, 32'h0000_0020};
        slave_ack   = '1;
        slave_rdata = {32'h1234_5678, 32'h9ABC_DEF0};
        repeat (2) @(posedge clk);
        #2;
        tests_run++;
        if ({slave_req, slave_cmd, master_ack, master_err} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_ctrl: got %b expected 0", {slave_req, slave_cmd, master_ack, master_err});
        end
        tests_run++;
        if ({slave_addr, slave_wdata, master_rdata} !== '0) begin
            tests_failed++;
            $display("[TB] FAIL reset_data: got %h expected 0", {slave_addr, slave_wdata, master_rdata});
        end
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        next_cycle();
    endtask

    task automatic test_single_read();
        apply_reset();
        set_master(0, 1'b1, 32'h0000_0010, CMD_READ, '0);
        @(negedge clk);
        tests_run++;
        if (slave_req !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL single_arb_cycle: slave_req got %b expected 00", slave_req);
        end
        next_cycle();
        @(negedge clk);
        tests_run++;
        if (slave_req !== 2'b01 || slave_addr[31:0] !== 32'h0000_0010 || slave_cmd[0] !== CMD_READ) begin
            tests_failed++;
            $display("[TB] FAIL single_grant: req %b addr %h cmd %b expected 01 00000010 0",
                     slave_req, slave_addr[31:0], slave_cmd[0]);
        end
        tests_run++;
        if (master_ack !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL single_early_ack: got %b expected 00", master_ack);
        end
        next_cycle();
        slave_ack[0]       = 1'b1;
        slave_rdata[31:0]  = 32'hDEAD_BEEF;
        @(negedge clk);
        tests_run++;
        if (master_ack !== 2'b01 || master_rdata !== {32'h0, 32'hDEAD_BEEF}) begin
            tests_failed++;
            $display("[TB] FAIL single_ack: ack %b rdata %h expected 01 00000000deadbeef", master_ack, master_rdata);
        end
        next_cycle();
        idle_inputs();
        @(negedge clk);
        tests_run++;
        if (slave_req !== 2'b00 || master_ack !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL single_release: req %b ack %b expected 00 00", slave_req, master_ack);
        end
        next_cycle();
    endtask

    task automatic test_parallel_write();
        apply_reset();
        set_master(0, 1'b1, 32'h0000_0004, CMD_WRITE, 32'h1111_1111);
        set_master(1, 1'b1, 32'h8000_0004, CMD_WRITE, 32'h2222_2222);
        next_cycle();
        @(negedge clk);
        tests_run++;
        if (slave_req !== 2'b11 || slave_cmd !== 2'b11 ||
            slave_wdata !== {32'h2222_2222, 32'h1111_1111} ||
            slave_addr !== {32'h8000_0004, 32'h0000_0004}) begin
            tests_failed++;
            $display("[TB] FAIL parallel_grant: req %b cmd %b wdata %h addr %h", slave_req, slave_cmd,
                     slave_wdata, slave_addr);
        end
        next_cycle();
        slave_ack   = 2'b11;
        slave_rdata = {32'hCAFE_F00D, 32'h5555_5555};
        @(negedge clk);
        tests_run++;
        if (master_ack !== 2'b11 || master_rdata !== '0 || master_err !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL parallel_ack: ack %b rdata %h err %b expected 11 0 00",
                     master_ack, master_rdata, master_err);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_fairness();
        int  ptr;
        int  expected;
        int  got;
        int  prev;
        int  repeats;
        bit  ok;
        logic [DATA_W-1:0] rd;
        apply_reset();
        ptr     = 0;
        prev    = -1;
        repeats = 0;
        set_master(0, 1'b1, 32'h8000_0100, CMD_READ, '0);
        set_master(1, 1'b1, 32'h8000_0200, CMD_READ, '0);
        for (int t = 0; t < 6; t++) begin
            wait_slave_req(1, ok);
            tests_run++;
            if (!ok) begin
                tests_failed++;
                $display("[TB] FAIL fair_wait: slave_req[1] got 0 expected 1 (transaction %0d)", t);
                break;
            end
            expected = ptr;
            ptr      = (ptr + 1) % NUM_M;
            got      = (slave_addr[63:32] == 32'h8000_0100) ? 0 :
                       (slave_addr[63:32] == 32'h8000_0200) ? 1 : -1;
            tests_run++;
            if (got != expected) begin
                tests_failed++;
                $display("[TB] FAIL fair_grant: transaction %0d owner got %0d expected %0d", t, got, expected);
            end
            if (got == prev) repeats++;
            prev = got;
            next_cycle();
            rd                 = $urandom;
            slave_ack[1]       = 1'b1;
            slave_rdata[63:32] = rd;
            @(negedge clk);
            tests_run++;
            if (master_ack !== NUM_M'(1 << expected) ||
                master_rdata[expected*DATA_W +: DATA_W] !== rd) begin
                tests_failed++;
                $display("[TB] FAIL fair_ack: ack %b rdata %h expected ack bit %0d rdata %h",
                         master_ack, master_rdata, expected, rd);
            end
            next_cycle();
            slave_ack[1] = 1'b0;
        end
        tests_run++;
        if (repeats != 0) begin
            tests_failed++;
            $display("[TB] FAIL fair_alternate: consecutive repeats got %0d expected 0", repeats);
        end
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_back_to_back();
        int ack_cyc;
        bit ok;
        apply_reset();
        set_master(0, 1'b1, 32'h0000_0100, CMD_READ, '0);
        wait_slave_req(0, ok);
        next_cycle();
        slave_ack[0]      = 1'b1;
        slave_rdata[31:0] = 32'h0BAD_F00D;
        @(negedge clk);
        ack_cyc = cyc;
        tests_run++;
        if (!ok || master_ack !== 2'b01) begin
            tests_failed++;
            $display("[TB] FAIL b2b_first_ack: ack %b granted %0d expected 01 1", master_ack, ok);
        end
        next_cycle();
        slave_ack[0] = 1'b0;
        set_master(0, 1'b1, 32'h0000_0200, CMD_WRITE, 32'h7777_0000);
        @(negedge clk);
        tests_run++;
        if (slave_req[0] !== 1'b0) begin
            tests_failed++;
            $display("[TB] FAIL b2b_gap: slave_req[0] got %b expected 0", slave_req[0]);
        end
        next_cycle();
        wait_slave_req(0, ok);
        tests_run++;
        if (!ok || cyc - ack_cyc != 2) begin
            tests_failed++;
            $display("[TB] FAIL b2b_spacing: cycles after ack got %0d expected 2", cyc - ack_cyc);
        end
        tests_run++;
        if (slave_addr[31:0] !== 32'h0000_0200 || slave_wdata[31:0] !== 32'h7777_0000) begin
            tests_failed++;
            $display("[TB] FAIL b2b_payload: addr %h wdata %h expected 00000200 77770000",
                     slave_addr[31:0], slave_wdata[31:0]);
        end
        next_cycle();
        slave_ack[0] = 1'b1;
        @(negedge clk);
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask

    task automatic test_reset_mid();
        bit ok;
        apply_reset();
        set_master(0, 1'b1, 32'h0000_0040, CMD_READ, '0);
        wait_slave_req(0, ok);
        next_cycle();
        rst_n             = 1'b0;
        slave_ack[0]      = 1'b1;
        slave_rdata[31:0] = 32'hFFFF_0000;
        #1;
        tests_run++;
        if (!ok || slave_req !== 2'b00 || master_ack !== 2'b00 || slave_addr !== '0) begin
            tests_failed++;
            $display("[TB] FAIL midreset_outputs: req %b ack %b addr %h expected 00 00 0",
                     slave_req, master_ack, slave_addr);
        end
        set_master(1, 1'b1, 32'h0000_0080, CMD_READ, '0);
        @(negedge clk);
        slave_ack = '0;
        rst_n     = 1'b1;
        next_cycle();
        wait_slave_req(0, ok);
        tests_run++;
        if (!ok || slave_addr[31:0] !== 32'h0000_0040) begin
            tests_failed++;
            $display("[TB] FAIL midreset_ptr: granted addr got %h expected 00000040", slave_addr[31:0]);
        end
        idle_inputs();
        next_cycle();
        next_cycle();
    endtask

    task automatic test_random();
        bit                pend     [NUM_M];
        int                tgt      [NUM_M];
        logic [ADDR_W-1:0] addr_q   [NUM_M];
        logic              cmd_q    [NUM_M];
        logic [DATA_W-1:0] wdata_q  [NUM_M];
        bit                mbusy    [NUM_S];
        int                mowner   [NUM_S];
        int                rr_ptr   [NUM_S];
        int                busy_len [NUM_S];
        logic [NUM_S-1:0]        exp_sreq;
        logic [NUM_M-1:0]        exp_ack;
        logic [NUM_M*DATA_W-1:0] exp_rdata;
        int                      done_cnt;
        int                      g;
        int                      c;
        apply_reset();
        done_cnt = 0;
        for (int i = 0; i < NUM_M; i++) pend[i] = 1'b0;
        for (int s = 0; s < NUM_S; s++) begin
            mbusy[s]    = 1'b0;
            mowner[s]   = 0;
            rr_ptr[s]   = 0;
            busy_len[s] = 0;
        end
        for (int t = 0; t < 600; t++) begin
            for (int m = 0; m < NUM_M; m++) begin
                if (!pend[m] && $urandom_range(0, 1) == 1) begin
                    pend[m]    = 1'b1;
                    tgt[m]     = $urandom_range(0, NUM_S - 1);
                    addr_q[m]  = (32'(tgt[m]) << 31) | ($urandom & 32'h7FFF_FF00) | 32'(m);
                    cmd_q[m]   = 1'($urandom_range(0, 1));
                    wdata_q[m] = $urandom;
                end
                set_master(m, pend[m], addr_q[m], cmd_q[m], wdata_q[m]);
            end
            for (int s = 0; s < NUM_S; s++) begin
                slave_ack[s]                   = 1'b0;
                slave_rdata[s*DATA_W +: DATA_W] = $urandom;
                if (slave_req[s] === 1'b1) begin
                    busy_len[s]++;
                    if (busy_len[s] >= 4 || $urandom_range(0, 2) == 0) slave_ack[s] = 1'b1;
                end else begin
                    busy_len[s] = 0;
                end
            end
            @(negedge clk);
            exp_ack   = '0;
            exp_rdata = '0;
            for (int s = 0; s < NUM_S; s++) begin
                exp_sreq[s] = mbusy[s];
                if (mbusy[s]) begin
                    tests_run++;
                    if (slave_addr[s*ADDR_W +: ADDR_W] !== addr_q[mowner[s]] ||
                        slave_cmd[s] !== cmd_q[mowner[s]] ||
                        slave_wdata[s*DATA_W +: DATA_W] !== wdata_q[mowner[s]]) begin
                        tests_failed++;
                        $display("[TB] FAIL rand_fwd: cycle %0d slave %0d addr %h expected %h (owner %0d)",
                                 t, s, slave_addr[s*ADDR_W +: ADDR_W], addr_q[mowner[s]], mowner[s]);
                    end
                    if (slave_ack[s]) begin
                        exp_ack[mowner[s]] = 1'b1;
                        exp_rdata[mowner[s]*DATA_W +: DATA_W] =
                            (cmd_q[mowner[s]] == CMD_READ) ? slave_rdata[s*DATA_W +: DATA_W] : '0;
                    end
                end
            end
            tests_run++;
            if (slave_req !== exp_sreq) begin
                tests_failed++;
                $display("[TB] FAIL rand_slave_req: cycle %0d got %b expected %b", t, slave_req, exp_sreq);
            end
            tests_run++;
            if (master_ack !== exp_ack || master_rdata !== exp_rdata || master_err !== '0) begin
                tests_failed++;
                $display("[TB] FAIL rand_master: cycle %0d ack %b/%b rdata %h/%h err %b (got/expected)",
                         t, master_ack, exp_ack, master_rdata, exp_rdata, master_err);
            end
            for (int s = 0; s < NUM_S; s++) begin
                if (mbusy[s]) begin
                    if (slave_ack[s]) begin
                        mbusy[s]       = 1'b0;
                        pend[mowner[s]] = 1'b0;
                        done_cnt++;
                    end
                end else begin
                    g = -1;
                    for (int k = 0; k < NUM_M; k++) begin
                        c = (rr_ptr[s] + k) % NUM_M;
                        if (g < 0 && pend[c] && tgt[c] == s) g = c;
                    end
                    if (g >= 0) begin
                        mbusy[s]  = 1'b1;
                        mowner[s] = g;
                        rr_ptr[s] = (g + 1) % NUM_M;
                    end
                end
            end
            next_cycle();
        end
        tests_run++;
        if (done_cnt < 50) begin
            tests_failed++;
            $display("[TB] FAIL rand_progress: completed %0d transactions expected at least 50", done_cnt);
        end
        idle_inputs();
        next_cycle();
    endtask

`ifdef CROSSBAR_TIMEOUT_EN
    task automatic test_timeout();
        bit ok;
        apply_reset();
        slave_rdata[31:0] = 32'hA5A5_A5A5;
        set_master(0, 1'b1, 32'h0000_0020, CMD_READ, '0);
        wait_slave_req(0, ok);
        for (int k = 1; k <= TIMEOUT; k++) begin
            if (k > 1) begin
                next_cycle();
                @(negedge clk);
            end
            tests_run++;
            if (k < TIMEOUT && (!ok || master_ack !== 2'b00 || slave_req[0] !== 1'b1)) begin
                tests_failed++;
                $display("[TB] FAIL timeout_wait: busy cycle %0d ack %b req %b expected 00 1", k, master_ack, slave_req[0]);
            end else if (k == TIMEOUT && (master_ack !== 2'b01 || master_err !== 2'b01 || master_rdata !== '0)) begin
                tests_failed++;
                $display("[TB] FAIL timeout_fire: ack %b err %b rdata %h expected 01 01 0",
                         master_ack, master_err, master_rdata);
            end
        end
        next_cycle();
        master_req = '0;
        @(negedge clk);
        tests_run++;
        if (slave_req[0] !== 1'b0 || master_ack !== 2'b00) begin
            tests_failed++;
            $display("[TB] FAIL timeout_release: req %b ack %b expected 0 00", slave_req[0], master_ack);
        end
        next_cycle();
        set_master(0, 1'b1, 32'h0000_0024, CMD_READ, '0);
        wait_slave_req(0, ok);
        for (int k = 2; k <= TIMEOUT; k++) begin
            next_cycle();
            if (k == TIMEOUT) slave_ack[0] = 1'b1;
        end
        @(negedge clk);
        tests_run++;
        if (!ok || master_ack !== 2'b01 || master_err !== 2'b00 || master_rdata[31:0] !== 32'hA5A5_A5A5) begin
            tests_failed++;
            $display("[TB] FAIL timeout_ack_wins: ack %b err %b rdata %h expected 01 00 a5a5a5a5",
                     master_ack, master_err, master_rdata[31:0]);
        end
        next_cycle();
        idle_inputs();
        next_cycle();
    endtask
`endif

    initial begin
        idle_inputs();
        test_reset();
        test_single_read();
        test_parallel_write();
        test_fairness();
        test_back_to_back();
        test_reset_mid();
        test_random();
`ifdef CROSSBAR_TIMEOUT_EN
        test_timeout();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
